uart_tx_feeder: RTL and testbench

UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

---
 rtl/uart_tx_feeder.sv | 131 +++++++++++++
 tb/tb_uart_tx_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Byte FIFO in front of a UART transmitter. The host writes bytes at up to
//   one per cycle. A small FSM pops one byte at a time and presents it on
//   tx_data. It strobes send for one cycle, then waits for a rising edge on
//   tx_done before it pops the next byte.
//
// Ports
//   tx_clk   : sole clock, rising edge
//   rst      : synchronous active-low reset
//   wr_en    : host write strobe
//   wr_data  : host byte
//   full     : FIFO holds DEPTH bytes (registered)
//   empty    : FIFO holds 0 bytes (registered)
//   count    : bytes currently stored (registered)
//   overflow : sticky flag, set when a write hit a full FIFO
//   tx_data  : byte for the transmitter; changes only on a pop
//   send     : one-cycle start strobe to the transmitter
//   tx_done  : frame-complete indication from the transmitter
//   busy     : a popped byte has not yet completed its frame
module uart_tx_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,              // power of 2, >= 2
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [DATA_W-1:0] tx_data,
  output logic              send,
  input  logic              tx_done,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  localparam logic [1:0] WAIT = 2'd3;

  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q,    state_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              full_q,     full_d;
  logic              empty_q,    empty_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] tx_data_q,  tx_data_d;
  logic              done_q,     done_d;

  logic wr_acc;
  logic pop;

  always_comb begin
    // full is the registered flag, so a pop on the same edge cannot make
    // room for this write.
    wr_acc     = wr_en & ~full_q;
    pop        = (state_q == IDLE) & ~empty_q;

    wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop    ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d    = count_q;
    if (wr_acc && !pop)      count_d = count_q + CNT_ONE;
    else if (pop && !wr_acc) count_d = count_q - CNT_ONE;

    full_d     = (count_d == CNT_MAX);
    empty_d    = (count_d == '0);
    overflow_d = overflow_q | (wr_en & full_q);
    tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    done_d     = tx_done;

    state_d    = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    state_d = WAIT;
      // Only a fresh rising edge ends the frame. A level left high from
      // an earlier frame is ignored.
      WAIT:    if (tx_done && !done_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  // Storage is not reset. Entries are only ever read after being written.
  always_ff @(posedge tx_clk) begin
    if (rst && wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign tx_data  = tx_data_q;
  assign send     = (state_q == SEND);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
module tb_uart_tx_feeder;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, empty, overflow, send, busy, tx_done;
  logic [4:0] count;
  logic [7:0] tx_data;

  int n_cmp = 0;
  int n_err = 0;
  int n_send = 0;
  int s0;

  uart_tx_feeder #(.DATA_W(8), .DEPTH(16)) dut (
    .tx_clk(tx_clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_data(tx_data), .send(send), .tx_done(tx_done), .busy(busy)
  );

  always #5 tx_clk = ~tx_clk;

  always @(negedge tx_clk) if (send) n_send++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  // Wait for the send strobe and check the presented byte. Check that the
  // strobe lasts one cycle, then complete the frame with a tx_done pulse.
  task automatic serve(input logic [7:0] exp);
    int k = 0;
    while (!send && k < 40) begin
      tick();
      k++;
    end
    if (!send) begin
      chk("send_timeout", 32'(k), 32'd0);
      return;
    end
    chk("serve_data", 32'(tx_data), 32'(exp));
    tick();
    chk("send_one_cycle", 32'(send), 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, with a write held active to show that reset takes priority.
    rst = 1'b0; wr_en = 1'b1; wr_data = 8'hFF; tx_done = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_send", 32'(send), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_txd", 32'(tx_data), 0);
    wr_en = 1'b0; rst = 1'b1;
    tick();

    // Single byte, latency check.
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();                          // E0
    wr_en = 1'b0;
    chk("sb_count", 32'(count), 1);
    chk("sb_empty", 32'(empty), 0);
    chk("sb_busy0", 32'(busy), 0);
    tick();                          // E0+1: pop
    chk("sb_txd", 32'(tx_data), 32'hA5);
    chk("sb_busy1", 32'(busy), 1);
    chk("sb_send_load", 32'(send), 0);
    chk("sb_count0", 32'(count), 0);
    tick();                          // E0+2: SEND
    chk("sb_send", 32'(send), 1);
    tick();                          // E0+3: WAIT
    chk("sb_send_wait", 32'(send), 0);
    chk("sb_busy_wait", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    chk("sb_done_busy", 32'(busy), 0);
    tx_done = 1'b0;
    tick();

    // Stale tx_done: high before the pop and held across SEND into WAIT.
    wr_en = 1'b1; wr_data = 8'h3C;
    tick();
    wr_en = 1'b0; tx_done = 1'b1;
    tick();                          // pop -> LOAD
    tick();                          // SEND
    chk("st_send", 32'(send), 1);
    tick(); tick(); tick();
    chk("st_hold_busy", 32'(busy), 1);
    tx_done = 1'b0;
    tick();
    chk("st_low_busy", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    chk("st_rise_busy", 32'(busy), 0);
    tx_done = 1'b0;
    tick();

    // Fill: 17 writes with one pop leaves 16 stored. The 18th is dropped.
    for (int i = 0; i <= 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    chk("fill_count", 32'(count), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf0", 32'(overflow), 0);
    chk("fill_txd", 32'(tx_data), 0);
    wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    chk("ovf_count", 32'(count), 16);
    chk("ovf_set", 32'(overflow), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();                          // pop 0x01
    chk("ovf_pop_txd", 32'(tx_data), 1);
    chk("ovf_pop_count", 32'(count), 15);
    chk("ovf_pop_full", 32'(full), 0);
    for (int i = 1; i <= 16; i++) serve(8'(i));
    chk("drain_empty", 32'(empty), 1);
    chk("ovf_sticky", 32'(overflow), 1);

    // 40-byte stream with wrap. The writer backs off while the FIFO is full.
    s0 = n_send;
    fork
      begin
        int n = 0;
        while (n < 40) begin
          if (!full) begin
            wr_en = 1'b1; wr_data = 8'(n); n++;
          end else wr_en = 1'b0;
          tick();
        end
        wr_en = 1'b0;
      end
      begin
        for (int i = 0; i < 40; i++) serve(8'(i));
      end
    join
    chk("stream_sends", 32'(n_send - s0), 40);
    chk("stream_empty", 32'(empty), 1);

    // Simultaneous write and pop at count=3.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("sim_pre_count", 32'(count), 3);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0; wr_en = 1'b1; wr_data = 8'h54;
    tick();                          // pop 0x51 together with write 0x54
    wr_en = 1'b0;
    chk("sim_count", 32'(count), 3);
    chk("sim_txd", 32'(tx_data), 32'h51);
    for (int i = 1; i <= 4; i++) serve(8'(8'h50 + i));
    chk("sim_empty", 32'(empty), 1);

    // Reset in WAIT with count=5.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("rw_busy", 32'(busy), 1);
    chk("rw_count", 32'(count), 5);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rw_count0", 32'(count), 0);
    chk("rw_empty", 32'(empty), 1);
    chk("rw_busy0", 32'(busy), 0);
    chk("rw_send0", 32'(send), 0);
    chk("rw_ovf0", 32'(overflow), 0);
    chk("rw_txd0", 32'(tx_data), 0);
    s0 = n_send;
    repeat (6) tick();
    chk("rw_no_send", 32'(n_send - s0), 0);
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    serve(8'h77);
    chk("rw_final_empty", 32'(empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
